sram_access_seq: RTL and testbench
==================================

SRAM_ACCESS_SEQ -- requirements
Module: sram_access_seq

Interface
REQ-001 Parameter: PRE_CYCLES, 2, bitline precharge duration in cycles (legal range 1..15).
REQ-002 Parameter: WL_CYCLES, 2, word-line active duration in cycles (legal range 1..15).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  Clock; all state is updated on the rising edge.
REQ-005 rst_n  in  1  Asynchronous, active-low reset.
REQ-006 req_valid  in  1  Request valid.
REQ-007 req_ready  out  1  Sequencer can accept a request.
REQ-008 req_write  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  7  Row address (0..127).
REQ-010 req_wdata  in  256  Write row data.
REQ-011 rsp_valid  out  1  Response valid.
REQ-012 rsp_ready  in  1  Response accepted.
REQ-013 rsp_write  out  1  Echo of req_write for the response.
REQ-014 rsp_rdata  out  256  Read row data.
REQ-015 row_addr  out  7  Row address to the row decoder.
REQ-016 en_pcomp  out  1  Row decoder enable.
REQ-017 pre_en  out  1  Bitline precharge enable.
REQ-018 wl_en  out  1  Word-line timing enable.
REQ-019 we  out  1  Write-driver enable.
REQ-020 sae  out  1  Sense-amp enable.
REQ-021 bl_wdata  out  256  Data driven to the write drivers.
REQ-022 arr_rdata  in  256  Sense-amp outputs.

Function
REQ-023 The sequencer SHALL use the states IDLE, PRE, DEC, WL, SENSE and RESP, with every output driven from registers.
REQ-024 req_ready SHALL be 1 only in IDLE.
- A handshake is req_valid & req_ready in cycle T.
- On a handshake, the block captures req_write, req_addr and req_wdata and enters PRE at T+1.
REQ-025 In PRE, pre_en SHALL be 1 for exactly PRE_CYCLES cycles.
- row_addr holds the captured address.
- The state then advances to DEC.
REQ-026 In DEC, the block SHALL hold all enables at 0 for exactly 1 cycle (address settle, precharge/word-line gap), then advance to WL.
REQ-027 In WL, en_pcomp and wl_en SHALL be 1 for exactly WL_CYCLES cycles.
- For writes, we is 1 and bl_wdata equals the captured wdata.
- For reads, we is 0.
REQ-028 A read SHALL leave WL for SENSE.
- In SENSE, en_pcomp and sae are 1 for 1 cycle.
- arr_rdata is captured into rsp_rdata at the end of the SENSE cycle.
- The state then advances to RESP.
REQ-029 A write SHALL leave WL directly for RESP, and rsp_rdata SHALL keep its previous value.
REQ-030 In RESP, rsp_valid SHALL be 1 and rsp_write SHALL equal the captured req_write.
- rsp_valid, rsp_write and rsp_rdata stay stable until rsp_ready is sampled 1.
- The state then returns to IDLE.
REQ-031 First rsp_valid cycle SHALL be T+PRE_CYCLES+WL_CYCLES+3 for reads and T+PRE_CYCLES+WL_CYCLES+2 for writes (defaults: T+7, T+6).
REQ-032 pre_en SHALL never be 1 in the same cycle as wl_en, en_pcomp, we or sae.
REQ-033 sae SHALL never be 1 during a write, and we SHALL never be 1 during a read.
REQ-034 Changes on req_* inputs while not in IDLE SHALL be ignored.
- There is no request queueing.
- The earliest next handshake is the cycle after the RESP handshake.
REQ-035 A single PRE_CYCLES/WL_CYCLES down-counter SHALL be used.
- It is 4 bits wide, loaded on state entry.
- The state advances when the counter reaches 1.
REQ-036 Address 127 and address 0 SHALL behave identically to any other row; row_addr does not wrap or increment.

Reset
REQ-037 While rst_n=0, asynchronously:
- State = IDLE; req_ready = 0.
- rsp_valid, rsp_write, en_pcomp, pre_en, wl_en, we and sae = 0.
- row_addr = 0; bl_wdata = 0; rsp_rdata = 0.
REQ-038 req_ready SHALL rise on the first rising clk edge after rst_n deasserts.
REQ-039 Reset asserted mid-transaction SHALL abort that transaction.
- All enables fall immediately (asynchronously).
- No response is produced for the aborted transaction.

Verification
REQ-040 Write of addr 0x05, data all-ones, defaults, rsp_ready=1 -> the bench SHALL see:
- pre_en at T+1..T+2; DEC at T+3.
- wl_en/en_pcomp/we at T+4..T+5.
- rsp_valid=1, rsp_write=1 at T+6.
REQ-041 Read of addr 0x7F with arr_rdata=0xA5 repeated -> the bench SHALL see sae at T+6 only, and rsp_valid at T+7 with rsp_rdata=0xA5 repeated.
REQ-042 Read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata SHALL hold stable, and req_ready SHALL stay 0 until the cycle after rsp_ready=1.
REQ-043 req_addr toggled every cycle during a transaction -> row_addr SHALL stay equal to the captured value throughout.
REQ-044 rst_n pulsed low during WL of a write -> we, wl_en and en_pcomp SHALL drop to 0 without a clock edge, and no rsp_valid SHALL follow.
REQ-045 PRE_CYCLES=1 and WL_CYCLES=1 read -> rsp_valid SHALL be observed at T+5.

Source files
------------

// File: rtl/sram_access_seq_if.sv
// rtl/sram_access_seq_if.sv - request/response and array-side signals of the SRAM access sequencer
// master is the requester plus array model; slave is the sequencer.
interface sram_access_seq_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [6:0]   req_addr;
  logic [255:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_write;
  logic [255:0] rsp_rdata;
  logic [6:0]   row_addr;
  logic         en_pcomp;
  logic         pre_en;
  logic         wl_en;
  logic         we;
  logic         sae;
  logic [255:0] bl_wdata;
  logic [255:0] arr_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, arr_rdata,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata, row_addr,
           en_pcomp, pre_en, wl_en, we, sae, bl_wdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, arr_rdata,
    output req_ready, rsp_valid, rsp_write, rsp_rdata, row_addr,
           en_pcomp, pre_en, wl_en, we, sae, bl_wdata
  );
endinterface

// File: rtl/sram_access_seq.sv
// rtl/sram_access_seq.sv - single-row SRAM access sequencer (precharge, decode, word line, sense)
// Every output is a register; each state transition also sets the outputs for the next cycle.
module sram_access_seq #(
  parameter int unsigned PRE_CYCLES = 2,
  parameter int unsigned WL_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_access_seq_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, PRE, DEC, WL, SENSE, RESP} state_e;

  localparam logic [3:0] PRE_LD = 4'(PRE_CYCLES);
  localparam logic [3:0] WL_LD  = 4'(WL_CYCLES);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          write_q;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic          rsp_write_q;
  logic [255:0]  rsp_rdata_q;
  logic [6:0]    row_addr_q;
  logic          en_pcomp_q;
  logic          pre_en_q;
  logic          wl_en_q;
  logic          we_q;
  logic          sae_q;
  logic [255:0]  bl_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      row_addr_q  <= 7'd0;
      en_pcomp_q  <= 1'b0;
      pre_en_q    <= 1'b0;
      wl_en_q     <= 1'b0;
      we_q        <= 1'b0;
      sae_q       <= 1'b0;
      bl_wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Ready comes up one edge after reset and stays up until a handshake.
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            write_q     <= bus.req_write;
            row_addr_q  <= bus.req_addr;
            if (bus.req_write) begin
              bl_wdata_q <= bus.req_wdata;
            end
            cnt_q    <= PRE_LD;
            pre_en_q <= 1'b1;
            state_q  <= PRE;
          end
        end
        PRE: begin
          if (cnt_q == 4'd1) begin
            pre_en_q <= 1'b0;
            state_q  <= DEC;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DEC: begin
          en_pcomp_q <= 1'b1;
          wl_en_q    <= 1'b1;
          we_q       <= write_q;
          cnt_q      <= WL_LD;
          state_q    <= WL;
        end
        WL: begin
          if (cnt_q == 4'd1) begin
            wl_en_q <= 1'b0;
            we_q    <= 1'b0;
            if (write_q) begin
              en_pcomp_q  <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_write_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              // Decoder stays enabled through the sense cycle.
              sae_q   <= 1'b1;
              state_q <= SENSE;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        SENSE: begin
          sae_q       <= 1'b0;
          en_pcomp_q  <= 1'b0;
          rsp_rdata_q <= bus.arr_rdata;
          rsp_valid_q <= 1'b1;
          rsp_write_q <= 1'b0;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.row_addr  = row_addr_q;
  assign bus.en_pcomp  = en_pcomp_q;
  assign bus.pre_en    = pre_en_q;
  assign bus.wl_en     = wl_en_q;
  assign bus.we        = we_q;
  assign bus.sae       = sae_q;
  assign bus.bl_wdata  = bl_wdata_q;

endmodule

// File: tb/tb_sram_access_seq.sv
// tb/tb_sram_access_seq.sv - bench for sram_access_seq
// Timeline model: outputs derived from the cycle offset since the request handshake.
module tb_sram_access_seq;

  localparam int P = 2;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_access_seq_if bus ();
  sram_access_seq_if bus1 ();

  sram_access_seq #(.PRE_CYCLES(P), .WL_CYCLES(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  sram_access_seq #(.PRE_CYCLES(1), .WL_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model state: busy transaction, offset d from handshake cycle T.
  bit           m_busy = 1'b0;
  bit           m_w = 1'b0;
  bit           m_rr = 1'b0;
  int           m_d = 0;
  int           m_t0 = 0;
  logic [6:0]   m_row = '0;
  logic [255:0] m_bl = '0;
  logic [255:0] m_rdata = '0;
  bit e_pre, e_wl, e_sae, e_pc, e_we, e_rv;

  always_comb begin
    e_pre = m_busy && m_d >= 1 && m_d <= P;
    e_wl  = m_busy && m_d >= P + 2 && m_d <= P + W + 1;
    e_sae = m_busy && !m_w && m_d == P + W + 2;
    e_pc  = e_wl || e_sae;
    e_we  = e_wl && m_w;
    e_rv  = m_busy && m_d >= (m_w ? P + W + 2 : P + W + 3);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_w = 1'b0; m_rr = 1'b0; m_d = 0;
      m_row = '0; m_bl = '0; m_rdata = '0;
    end else begin
      if (!m_busy) begin
        if (m_rr && bus.req_valid) begin
          m_busy = 1'b1; m_d = 1; m_t0 = cyc; m_w = bus.req_write;
          m_row = bus.req_addr;
          if (bus.req_write) m_bl = bus.req_wdata;
          m_rr = 1'b0;
        end else begin
          m_rr = 1'b1;
        end
      end else begin
        if (e_sae) m_rdata = bus.arr_rdata;
        if (e_rv && bus.rsp_ready) begin
          m_busy = 1'b0; m_rr = 1'b1;
        end else begin
          m_d = m_d + 1;
        end
      end
      cyc = cyc + 1;
    end
  end

  always @(negedge clk) begin
    chk("req_ready", bus.req_ready, m_rr);
    chk("rsp_valid", bus.rsp_valid, e_rv);
    chk("pre_en", bus.pre_en, e_pre);
    chk("wl_en", bus.wl_en, e_wl);
    chk("en_pcomp", bus.en_pcomp, e_pc);
    chk("we", bus.we, e_we);
    chk("sae", bus.sae, e_sae);
    chk("row_addr", bus.row_addr, m_row);
    chk("rsp_rdata", bus.rsp_rdata, m_rdata);
    if (e_rv) chk("rsp_write", bus.rsp_write, m_w);
    if (e_we) chk("bl_wdata", bus.bl_wdata, m_bl);
  end

  logic [15:0]  tr_pre, tr_wl, tr_we, tr_sae, tr_rv, tr_rr;
  logic [255:0] tr_bl, tr_rd;
  logic         tr_rw;
  int           tr_row_bad, tr_hold_bad, tr_excl_bad;

  task automatic run_txn(input bit wr, input logic [6:0] a, input logic [255:0] wd,
                         input logic [255:0] rd, input int stall, input bit toggle);
    int t0;
    int k;
    int stall_left;
    tr_pre = '0; tr_wl = '0; tr_we = '0; tr_sae = '0; tr_rv = '0; tr_rr = '0;
    tr_bl = '0; tr_rd = '0; tr_rw = 1'b0;
    tr_row_bad = 0; tr_hold_bad = 0; tr_excl_bad = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = wd;
    bus.arr_rdata = rd; bus.rsp_ready = (stall == 0);
    t0 = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (m_busy) begin t0 = m_t0; break; end
    end
    if (t0 < 0) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_timeout: got no handshake expected handshake within 20 cycles");
      bus.req_valid = 1'b0;
      return;
    end
    if (!toggle) bus.req_valid = 1'b0;
    stall_left = stall;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      k = cyc - t0;
      if (k < 16) begin
        tr_pre[k] = bus.pre_en; tr_wl[k] = bus.wl_en; tr_we[k] = bus.we;
        tr_sae[k] = bus.sae; tr_rv[k] = bus.rsp_valid; tr_rr[k] = bus.req_ready;
      end
      if (bus.we) tr_bl = bus.bl_wdata;
      if (bus.rsp_valid) begin tr_rd = bus.rsp_rdata; tr_rw = bus.rsp_write; end
      if (bus.rsp_valid && !wr && bus.rsp_rdata !== rd) tr_hold_bad++;
      if (bus.row_addr !== a) tr_row_bad++;
      if (bus.pre_en && (bus.wl_en || bus.en_pcomp || bus.we || bus.sae)) tr_excl_bad++;
      if (toggle) begin
        bus.req_addr = ~bus.req_addr; bus.req_wdata = ~bus.req_wdata;
        bus.req_write = ~bus.req_write; bus.req_valid = !e_rv && m_busy;
      end
      if (e_rv) begin
        if (stall_left > 0) begin bus.rsp_ready = 1'b0; stall_left--; end
        else bus.rsp_ready = 1'b1;
      end
      if (!m_busy) break;
    end
    if (m_busy) begin
      n_checks++; n_fail++;
      $display("FAIL txn_timeout: got still busy expected done within 40 cycles");
    end
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got time limit expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] ones;
    logic [255:0] pat_a5, pat_3c, pat_5a, pat_de;
    int t0, t1, k, cnt;
    logic [15:0] t1_pre, t1_wl, t1_sae, t1_rv;
    logic [255:0] t1_rd;
    ones = '1;
    pat_a5 = {32{8'hA5}}; pat_3c = {32{8'h3C}}; pat_5a = {32{8'h5A}};
    pat_de = {8{32'hDEADBEEF}};
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b1; bus.arr_rdata = '0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    bus1.rsp_ready = 1'b1; bus1.arr_rdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_pre_en", bus.pre_en, 1'b0);
    chk("rst_row_addr", bus.row_addr, 7'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 256'd0);
    chk("rst_bl_wdata", bus.bl_wdata, 256'd0);
    rst_n = 1'b1;
    #1 chk("rst_rel_ready_low", bus.req_ready, 1'b0);
    @(negedge clk);
    chk("rst_rel_ready_high", bus.req_ready, 1'b1);

    run_txn(1'b1, 7'h05, ones, 256'd0, 0, 1'b0);
    chk("w_pre", tr_pre, 16'h0006);
    chk("w_wl", tr_wl, 16'h0030);
    chk("w_we", tr_we, 16'h0030);
    chk("w_sae", tr_sae, 16'h0000);
    chk("w_rv", tr_rv, 16'h0040);
    chk("w_rr", tr_rr, 16'h0080);
    chk("w_bl", tr_bl, ones);
    chk("w_rsp_write", tr_rw, 1'b1);

    run_txn(1'b0, 7'h7F, 256'd0, pat_a5, 0, 1'b0);
    chk("r_pre", tr_pre, 16'h0006);
    chk("r_wl", tr_wl, 16'h0030);
    chk("r_we", tr_we, 16'h0000);
    chk("r_sae", tr_sae, 16'h0040);
    chk("r_rv", tr_rv, 16'h0080);
    chk("r_rdata", tr_rd, pat_a5);
    chk("r_rsp_write", tr_rw, 1'b0);
    chk("r_row", tr_row_bad, 0);

    run_txn(1'b0, 7'h00, 256'd0, pat_3c, 5, 1'b0);
    chk("stall_rv", tr_rv, 16'h1F80);
    chk("stall_rr", tr_rr, 16'h2000);
    chk("stall_hold", tr_hold_bad, 0);
    chk("stall_rdata", tr_rd, pat_3c);

    run_txn(1'b1, 7'h10, pat_de, pat_a5, 0, 1'b1);
    chk("tog_row", tr_row_bad, 0);
    chk("tog_bl", tr_bl, pat_de);
    chk("tog_rdata_kept", tr_rd, pat_3c);
    chk("tog_rv", tr_rv, 16'h0040);
    chk("tog_excl", tr_excl_bad, 0);

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 7'h33; bus.req_wdata = pat_de;
    t0 = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (m_busy) begin t0 = m_t0; break; end
    end
    bus.req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cyc - t0 == 4) break;
    end
    chk("abort_wl_before", bus.wl_en, 1'b1);
    chk("abort_we_before", bus.we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we", bus.we, 1'b0);
    chk("abort_wl_en", bus.wl_en, 1'b0);
    chk("abort_en_pcomp", bus.en_pcomp, 1'b0);
    chk("abort_row_addr", bus.row_addr, 7'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) cnt++;
    end
    chk("abort_no_rsp", cnt, 0);
    chk("abort_ready_back", bus.req_ready, 1'b1);

    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_addr = 7'h01;
    bus1.arr_rdata = pat_5a; bus1.rsp_ready = 1'b1;
    t1 = -1;
    for (int i = 0; i < 10; i++) begin
      if (bus1.req_ready) begin t1 = cyc; @(negedge clk); break; end
      @(negedge clk);
    end
    bus1.req_valid = 1'b0;
    t1_pre = '0; t1_wl = '0; t1_sae = '0; t1_rv = '0; t1_rd = '0;
    if (t1 < 0) begin
      n_checks++; n_fail++;
      $display("FAIL p1_handshake_timeout: got no ready expected ready within 10 cycles");
    end else begin
      for (int i = 0; i < 8; i++) begin
        k = cyc - t1;
        if (k >= 0 && k < 16) begin
          t1_pre[k] = bus1.pre_en; t1_wl[k] = bus1.wl_en;
          t1_sae[k] = bus1.sae; t1_rv[k] = bus1.rsp_valid;
        end
        if (bus1.rsp_valid) t1_rd = bus1.rsp_rdata;
        @(negedge clk);
      end
    end
    chk("p1_pre", t1_pre, 16'h0002);
    chk("p1_wl", t1_wl, 16'h0008);
    chk("p1_sae", t1_sae, 16'h0010);
    chk("p1_rv", t1_rv, 16'h0020);
    chk("p1_rdata", t1_rd, pat_5a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
